// File: rtl/tx_fram_arb.sv
// ---------------------------------------------------------------------------
// tx_fram_arb
//   Two-requester, packet-atomic round-robin arbiter feeding a single 64b/66b
//   PCS transmit port. A requester keeps the grant from its first block
//   until the block flagged "last", and only then can the other requester win.
//   One output register sits between the requesters and the PCS
//   (latency 1, full valid/ready handshake).
//
// Parameters
//   MAX_BLK   blocks per packet allowed before ovr_err is raised
//
// Ports
//   clk                 PCS tx_clk, the only clock
//   rst                 synchronous active-high reset
//   in0_dat / in1_dat   66-bit blocks, sync header [65:64], payload [63:0]
//   in0_vld / in1_vld   block valid from each requester
//   in0_last / in1_last final block of the current packet
//   in0_rdy / in1_rdy   block accepted this cycle (when paired with vld)
//   out_dat / out_vld   registered block to the PCS
//   out_rdy             PCS ready
//   pkt_cnt0 / pkt_cnt1 completed packets per requester (wrapping)
//   ovr_err             sticky: a packet ran past MAX_BLK blocks
//
// Build option
//   TX_FRAM_ARB_IDLE_INS_EN  when defined, an empty output register is
//                            refilled with an idle control block so out_vld
//                            stays high after reset.
// ---------------------------------------------------------------------------
module tx_fram_arb #(
    parameter int MAX_BLK = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [65:0] in0_dat,
    input  logic        in0_vld,
    input  logic        in0_last,
    output logic        in0_rdy,
    input  logic [65:0] in1_dat,
    input  logic        in1_vld,
    input  logic        in1_last,
    output logic        in1_rdy,
    output logic [65:0] out_dat,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [15:0] pkt_cnt0,
    output logic [15:0] pkt_cnt1,
    output logic        ovr_err
);

    // The block counter saturates at MAX_BLK; any further transfer is an overrun.
    localparam int               CNT_W     = $clog2(MAX_BLK + 1);
    localparam logic [CNT_W-1:0] MAX_BLK_C = CNT_W'(MAX_BLK);

`ifdef TX_FRAM_ARB_IDLE_INS_EN
    localparam logic [65:0] IDLE_BLK = {2'b10, 64'h0000_0000_0000_001E};
`endif

    typedef enum logic {
        ARB  = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q,    state_d;
    logic             grant_q,    grant_d;
    logic             ptr_q,      ptr_d;
    logic [CNT_W-1:0] blk_cnt_q,  blk_cnt_d;
    logic             ovr_err_q,  ovr_err_d;
    logic [15:0]      pkt_cnt0_q, pkt_cnt0_d;
    logic [15:0]      pkt_cnt1_q, pkt_cnt1_d;
    logic [65:0]      out_dat_q,  out_dat_d;
    logic             out_vld_q,  out_vld_d;

    logic        load_ok;   // output register can take a block this cycle
    logic        xfer;      // granted requester hands over a block
    logic        sel_last;
    logic [65:0] sel_dat;

    assign load_ok  = !out_vld_q || out_rdy;
    assign xfer     = grant_q ? (in1_vld && in1_rdy) : (in0_vld && in0_rdy);
    assign sel_last = grant_q ? in1_last : in0_last;
    assign sel_dat  = grant_q ? in1_dat  : in0_dat;

    // ---------------- state register ----------------
    // NOTE: every flop is written with <= so all state updates see the
    // pre-edge values; blocking assignments here would create order races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB;
            grant_q    <= 1'b0;
            ptr_q      <= 1'b0;
            blk_cnt_q  <= '0;
            ovr_err_q  <= 1'b0;
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
            out_dat_q  <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            blk_cnt_q  <= blk_cnt_d;
            ovr_err_q  <= ovr_err_d;
            pkt_cnt0_q <= pkt_cnt0_d;
            pkt_cnt1_q <= pkt_cnt1_d;
            out_dat_q  <= out_dat_d;
            out_vld_q  <= out_vld_d;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: each signal gets a hold/default value first so no path through
    // the case leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        blk_cnt_d  = blk_cnt_q;
        ovr_err_d  = ovr_err_q;
        pkt_cnt0_d = pkt_cnt0_q;
        pkt_cnt1_d = pkt_cnt1_q;

        unique case (state_q)
            ARB: begin
                if (in0_vld || in1_vld) begin
                    state_d   = BUSY;
                    blk_cnt_d = '0;
                    // Contention goes to ptr; otherwise to whoever asks.
                    grant_d   = (in0_vld && in1_vld) ? ptr_q : in1_vld;
                end
            end
            BUSY: begin
                // The grant is held until "last", even if vld drops mid-packet.
                if (xfer) begin
                    if (blk_cnt_q >= MAX_BLK_C) begin
                        ovr_err_d = 1'b1;
                    end else begin
                        blk_cnt_d = blk_cnt_q + CNT_W'(1);
                    end
                    if (sel_last) begin
                        state_d = ARB;
                        ptr_d   = ~grant_q;
                        if (grant_q) begin
                            pkt_cnt1_d = pkt_cnt1_q + 16'd1;
                        end else begin
                            pkt_cnt0_d = pkt_cnt0_q + 16'd1;
                        end
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Output register: load on transfer, hold while the PCS stalls,
    // otherwise drain (or refill with idle).
    always_comb begin
        out_dat_d = out_dat_q;
        out_vld_d = out_vld_q;
        if (xfer) begin
            out_dat_d = sel_dat;
            out_vld_d = 1'b1;
        end else if (load_ok) begin
`ifdef TX_FRAM_ARB_IDLE_INS_EN
            out_dat_d = IDLE_BLK;
            out_vld_d = 1'b1;
`else
            out_vld_d = 1'b0;
`endif
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        in0_rdy = (state_q == BUSY) && !grant_q && load_ok;
        in1_rdy = (state_q == BUSY) &&  grant_q && load_ok;
    end

    assign out_dat  = out_dat_q;
    assign out_vld  = out_vld_q;
    assign pkt_cnt0 = pkt_cnt0_q;
    assign pkt_cnt1 = pkt_cnt1_q;
    assign ovr_err  = ovr_err_q;

endmodule

// File: tb/tb_tx_fram_arb.sv
// ---------------------------------------------------------------------------
// tb_tx_fram_arb
//   Directed bench for tx_fram_arb (MAX_BLK = 4). Inputs change 1 time unit
//   after each rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_tx_fram_arb;

`ifdef TX_FRAM_ARB_IDLE_INS_EN
    localparam bit IDLE_EN = 1'b1;
`else
    localparam bit IDLE_EN = 1'b0;
`endif
    localparam logic [65:0] IDLE_BLK = {2'b10, 64'h0000_0000_0000_001E};

    logic        clk;
    logic        rst;
    logic [65:0] in0_dat, in1_dat;
    logic        in0_vld, in1_vld;
    logic        in0_last, in1_last;
    logic        in0_rdy, in1_rdy;
    logic [65:0] out_dat;
    logic        out_vld;
    logic        out_rdy;
    logic [15:0] pkt_cnt0, pkt_cnt1;
    logic        ovr_err;

    int n_chk = 0;
    int n_err = 0;

    tx_fram_arb #(.MAX_BLK(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in0_dat  (in0_dat),
        .in0_vld  (in0_vld),
        .in0_last (in0_last),
        .in0_rdy  (in0_rdy),
        .in1_dat  (in1_dat),
        .in1_vld  (in1_vld),
        .in1_last (in1_last),
        .in1_rdy  (in1_rdy),
        .out_dat  (out_dat),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .pkt_cnt0 (pkt_cnt0),
        .pkt_cnt1 (pkt_cnt1),
        .ovr_err  (ovr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct, header-varying test block for requester req, index idx.
    function automatic logic [65:0] blk(input int req, input int idx);
        logic [1:0]  hdr;
        logic [7:0]  r8;
        logic [31:0] lo;
        hdr = (idx % 2 == 1) ? 2'b10 : 2'b01;
        r8  = 8'(req);
        lo  = 32'(idx) * 32'h1111_1111;
        return {hdr, r8, 24'hABCDEF, lo};
    endfunction

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_vld"}, out_vld, 1'b0);
        check({tag, "_out_dat"}, out_dat, 66'h0);
        check({tag, "_in0_rdy"}, in0_rdy, 1'b0);
        check({tag, "_in1_rdy"}, in1_rdy, 1'b0);
        check({tag, "_cnt0"}, pkt_cnt0, 16'd0);
        check({tag, "_cnt1"}, pkt_cnt1, 16'd0);
        check({tag, "_ovr"}, ovr_err, 1'b0);
    endtask

    int i0, i1, g, idx;

    initial begin
        rst = 1'b1;
        in0_dat = '0; in0_vld = 1'b0; in0_last = 1'b0;
        in1_dat = '0; in1_vld = 1'b0; in1_last = 1'b0;
        out_rdy = 1'b1;
        tick();
        tick();
        check_reset_state("rst");

        // ---- no requests: idle blocks or nothing ----
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("idle_vld", out_vld, IDLE_EN);
            check("idle_dat", out_dat, IDLE_EN ? IDLE_BLK : 66'h0);
        end

        // ---- both requesters stream 2-block packets: grant 0,1,0,1 ----
        i0 = 0; i1 = 0;
        in0_vld = 1'b1; in0_dat = blk(0, i0); in0_last = 1'b0;
        in1_vld = 1'b1; in1_dat = blk(1, i1); in1_last = 1'b0;
        for (int p = 0; p < 4; p++) begin
            g = p % 2;
            tick();                               // arbitration edge
            check("rr_arb_vld", out_vld, IDLE_EN);
            check("rr_rdy_win", (g == 1) ? in1_rdy : in0_rdy, 1'b1);
            check("rr_rdy_lose", (g == 1) ? in0_rdy : in1_rdy, 1'b0);
            for (int b = 0; b < 2; b++) begin
                tick();
                idx = (g == 1) ? i1 : i0;
                check("rr_dat", out_dat, blk(g, idx));
                check("rr_vld", out_vld, 1'b1);
                if (g == 1) begin
                    i1++; in1_dat = blk(1, i1); in1_last = (i1 % 2 == 1);
                end else begin
                    i0++; in0_dat = blk(0, i0); in0_last = (i0 % 2 == 1);
                end
            end
            if (p % 2 == 1) begin
                check("rr_cnt0", pkt_cnt0, 16'((p + 1) / 2));
                check("rr_cnt1", pkt_cnt1, 16'((p + 1) / 2));
            end
        end
        in0_vld = 1'b0; in0_last = 1'b0;
        in1_vld = 1'b0; in1_last = 1'b0;

        // ---- in0 alone, 3-block packet ----
        in0_vld = 1'b1; in0_dat = blk(0, 10);
        tick();
        check("a_in0_rdy", in0_rdy, 1'b1);
        check("a_in1_rdy", in1_rdy, 1'b0);
        check("a_vld_gap", out_vld, IDLE_EN);
        tick();
        check("a_dat0", out_dat, blk(0, 10));
        check("a_vld0", out_vld, 1'b1);
        in0_dat = blk(0, 11);
        tick();
        check("a_dat1", out_dat, blk(0, 11));
        check("a_in1_rdy_mid", in1_rdy, 1'b0);
        in0_dat = blk(0, 12); in0_last = 1'b1;
        tick();
        check("a_dat2", out_dat, blk(0, 12));
        check("a_cnt0", pkt_cnt0, 16'd3);
        check("a_rdy_after_last", in0_rdy, 1'b0);
        in0_vld = 1'b0; in0_last = 1'b0;
        tick();
        check("a_drain_vld", out_vld, IDLE_EN);

        // ---- in1 packet with a 5-cycle PCS stall ----
        in1_vld = 1'b1; in1_dat = blk(1, 20);
        tick();
        tick();
        check("c_dat0", out_dat, blk(1, 20));
        in1_dat = blk(1, 21);
        out_rdy = 1'b0;
        #1;
        check("c_rdy_stall_now", in1_rdy, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("c_hold_dat", out_dat, blk(1, 20));
            check("c_hold_vld", out_vld, 1'b1);
            check("c_hold_rdy", in1_rdy, 1'b0);
        end
        out_rdy = 1'b1;
        #1;
        check("c_rdy_resume", in1_rdy, 1'b1);
        tick();
        check("c_dat1", out_dat, blk(1, 21));
        in1_dat = blk(1, 22); in1_last = 1'b1;
        tick();
        check("c_dat2", out_dat, blk(1, 22));
        check("c_cnt1", pkt_cnt1, 16'd3);
        in1_vld = 1'b0; in1_last = 1'b0;
        tick();
        check("c_drain_vld", out_vld, IDLE_EN);

        // ---- overrun: exactly MAX_BLK blocks is fine ----
        in0_vld = 1'b1; in0_dat = blk(0, 30);
        tick();
        for (int k = 0; k < 4; k++) begin
            in0_dat = blk(0, 30 + k); in0_last = (k == 3);
            tick();
            check("d4_dat", out_dat, blk(0, 30 + k));
            check("d4_ovr", ovr_err, 1'b0);
        end
        check("d4_cnt0", pkt_cnt0, 16'd4);
        in0_vld = 1'b0; in0_last = 1'b0;
        tick();

        // ---- overrun: 6 blocks, flag on the 5th transfer ----
        in0_vld = 1'b1; in0_dat = blk(0, 40);
        tick();
        for (int k = 0; k < 6; k++) begin
            in0_dat = blk(0, 40 + k); in0_last = (k == 5);
            tick();
            check("d6_dat", out_dat, blk(0, 40 + k));
            check("d6_ovr", ovr_err, (k >= 4));
        end
        check("d6_cnt0", pkt_cnt0, 16'd5);
        in0_vld = 1'b0; in0_last = 1'b0;
        tick();
        check("d6_ovr_sticky", ovr_err, 1'b1);

        // ---- reset during block 2 of an in1 packet ----
        in1_vld = 1'b1; in1_dat = blk(1, 50);
        tick();
        tick();
        check("e_dat0", out_dat, blk(1, 50));
        in1_dat = blk(1, 51);
        tick();
        check("e_dat1", out_dat, blk(1, 51));
        in1_dat = blk(1, 52);
        rst = 1'b1;
        tick();
        check_reset_state("e_rst");
        rst = 1'b0;
        in0_vld = 1'b1; in0_dat = blk(0, 60); in0_last = 1'b0;
        in1_vld = 1'b1; in1_dat = blk(1, 61); in1_last = 1'b0;
        tick();
        check("e_in0_rdy", in0_rdy, 1'b1);
        check("e_in1_rdy", in1_rdy, 1'b0);
        tick();
        check("e_dat_in0", out_dat, blk(0, 60));
        check("e_cnt1", pkt_cnt1, 16'd0);
        in0_vld = 1'b0; in1_vld = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
